dmem_ctrl: RTL and testbench

//  Parametrised data-memory block for the CPU load/store path: word/half/byte stores with byte enables,

---
 rtl/dmem_pkg.sv | 61 ++++++
 rtl/dmem_bank.sv | 33 +++
 rtl/dmem_ctrl.sv | 94 +++++++++
 tb/tb_dmem_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_RSV = 2'b00;
  localparam logic [1:0] SZ_W   = 2'b01;
  localparam logic [1:0] SZ_H   = 2'b10;
  localparam logic [1:0] SZ_B   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  // Latched request; the word index is kept separately since its width depends on DEPTH_WORDS.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] wdata;
    logic        err;
  } req_t;

  // Misaligned or reserved-size access.
  function automatic logic misalign_f(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_W:    misalign_f = (lane != 2'd0);
      SZ_H:    misalign_f = lane[0];
      SZ_B:    misalign_f = 1'b0;
      default: misalign_f = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_W:    be_f = 4'b1111;
      SZ_H:    be_f = lane[1] ? 4'b1100 : 4'b0011;
      SZ_B:    be_f = 4'b0001 << lane;
      default: be_f = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data so every lane sees it; enables pick the bytes.
  function automatic logic [31:0] wrep_f(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_H:    wrep_f = {2{wd[15:0]}};
      SZ_B:    wrep_f = {4{wd[7:0]}};
      default: wrep_f = wd;
    endcase
  endfunction

  // Select the addressed lane bytes (little-endian) and extend to 32 bits.
  function automatic logic [31:0] ext_f(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_H:    ext_f = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_B:    ext_f = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      default: ext_f = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port byte-enabled RAM, registered read.
module dmem_bank #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // One port access per enable: byte-masked write or registered word read.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++)
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: request latch, range/alignment check, lane steering, response handshake.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [AW-1:0] idx_q;
  logic [31:0]   off, ram_rdata;
  logic          accept, ram_en, ram_we;

  assign off    = req_addr_i - BASE_ADDR;
  assign accept = (state_q == S_IDLE) && req_valid_i;

  always_comb begin
    req_d.we    = req_we_i;
    req_d.size  = req_size_i;
    req_d.uns   = req_unsigned_i;
    req_d.lane  = off[1:0];
    req_d.wdata = req_wdata_i;
    req_d.err   = (off >= 32'(4 * DEPTH_WORDS)) || misalign_f(req_size_i, off[1:0]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; errors still pass through ACCESS so latency matches a real access.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid_i)  state_d = S_ACCESS;
      S_ACCESS:                   state_d = S_RESP;
      S_RESP:   if (resp_ready_i) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Request latch, captured on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      req_q <= req_d;
      idx_q <= off[2 +: AW];
    end
  end

  // Outputs; the RAM read register is untouched during RESP so rdata holds steady.
  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_RESP);
    ram_en       = (state_q == S_ACCESS) && !req_q.err;
    ram_we       = ram_en && req_q.we;
    resp_err_o   = resp_valid_o && req_q.err;
    resp_rdata_o = '0;
    if (resp_valid_o && !req_q.err && !req_q.we)
      resp_rdata_o = ext_f(ram_rdata, req_q.size, req_q.lane, req_q.uns);
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_bank (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (be_f(req_q.size, req_q.lane)),
    .addr_i  (idx_q),
    .wdata_i (wrep_f(req_q.size, req_q.wdata)),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized + directed bench for dmem_ctrl against a byte-array reference model.
module tb_dmem_ctrl;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;
  localparam int          NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b01;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic [7:0]  mm [NB];
  int          checks = 0, errors = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dmem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular memory; applies stores and returns the expected response.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic e, output logic [31:0] r);
    logic [31:0] off;
    int n;
    off = addr - BASE;
    n = (sz == 2'b01) ? 4 : (sz == 2'b10) ? 2 : 1;
    e = (off >= NB) || (sz == 2'b00) || (off % n != 0);
    r = '0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++) mm[off + i] = 8'(wd >> (8 * i));
    end else begin
      for (int i = 0; i < n; i++) r = r | (32'(mm[off + i]) << (8 * i));
      if (n < 4 && !uns && r[8*n-1]) r = r | ~((32'd1 << (8 * n)) - 32'd1);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, output logic [31:0] got);
    logic e;
    logic [31:0] r, first;
    int n;
    model(we, sz, uns, addr, wd, e, r);
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    chk("access_valid", 32'(resp_valid), 32'd0);
    chk("access_ready", 32'(req_ready), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 8);
    chk("latency", 32'(n), 32'd1);
    chk("rdata", resp_rdata, r);
    chk("err", 32'(resp_err), 32'(e));
    first = resp_rdata;
    got = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, first);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NB; i++) mm[i] = 8'h00;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    // Known contents for every word the bench will read.
    for (int w = 0; w < 16; w++) xfer(1'b1, 2'b01, 1'b0, BASE + 32'(4 * w), 32'd0, 0, rd);
    xfer(1'b1, 2'b01, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'd0, 0, rd);

    // Reset in the middle of a store: nothing committed.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = BASE + 32'd4; req_wdata = 32'h55AA_55AA;
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = 1'b0;
    #1 chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, 2'b01, 1'b0, BASE + 32'd4, 32'd0, 0, rd);
    chk("rst_no_commit", rd, 32'd0);

    xfer(1'b1, 2'b01, 1'b0, BASE, 32'hDEAD_BEEF, 0, rd);
    xfer(1'b0, 2'b01, 1'b0, BASE, 32'd0, 0, rd);
    chk("lw", rd, 32'hDEAD_BEEF);
    xfer(1'b1, 2'b11, 1'b0, BASE + 32'd3, 32'h0000_0080, 0, rd);
    xfer(1'b0, 2'b11, 1'b0, BASE + 32'd3, 32'd0, 0, rd);
    chk("lb", rd, 32'hFFFF_FF80);
    xfer(1'b0, 2'b11, 1'b1, BASE + 32'd3, 32'd0, 0, rd);
    chk("lbu", rd, 32'h0000_0080);
    xfer(1'b0, 2'b01, 1'b0, BASE, 32'd0, 0, rd);
    chk("lw_after_sb", rd, 32'h80AD_BEEF);
    xfer(1'b1, 2'b10, 1'b0, BASE + 32'd2, 32'h0000_1234, 0, rd);
    xfer(1'b0, 2'b10, 1'b0, BASE + 32'd2, 32'd0, 0, rd);
    chk("lh", rd, 32'h0000_1234);
    xfer(1'b0, 2'b01, 1'b0, BASE, 32'd0, 0, rd);
    chk("lw_after_sh", rd, 32'h1234_BEEF);

    // Error cases, including a store that must not land.
    xfer(1'b0, 2'b01, 1'b0, BASE + 32'd2, 32'd0, 0, rd);
    xfer(1'b0, 2'b10, 1'b0, BASE + 32'd1, 32'd0, 0, rd);
    xfer(1'b0, 2'b01, 1'b0, BASE + 32'h1000, 32'd0, 0, rd);
    xfer(1'b0, 2'b00, 1'b0, BASE, 32'd0, 0, rd);
    xfer(1'b1, 2'b01, 1'b0, BASE + 32'd2, 32'hFFFF_FFFF, 0, rd);
    xfer(1'b1, 2'b00, 1'b0, BASE, 32'hFFFF_FFFF, 0, rd);
    xfer(1'b0, 2'b01, 1'b0, BASE, 32'd0, 0, rd);
    chk("err_untouched", rd, 32'h1234_BEEF);
    xfer(1'b1, 2'b01, 1'b0, BASE + 32'hFFC, 32'hA5A5_0001, 0, rd);
    xfer(1'b0, 2'b10, 1'b0, BASE + 32'hFFE, 32'd0, 5, rd);
    chk("last_word_lh", rd, 32'hFFFF_A5A5);

    // Random traffic with random backpressure.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0:       a = BASE + 32'hFFC + 32'($urandom_range(0, 3));
        1:       a = BASE + 32'h1000 + 32'($urandom_range(0, 4000));
        2:       a = BASE - 32'd1 - 32'($urandom_range(0, 4000));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, $urandom, $urandom_range(0, 3), rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
